// File: rtl/tmr_rc_adder_pkg.sv
// Shared types for the triplicated ripple-carry adder: fault net codes and per-replica fault config.
// No logic; constants only.
// Backpressure: n/a.
package tmr_rc_adder_pkg;

  localparam int         NUM_REP = 3;
  localparam logic [1:0] BCAST   = 2'd3;
  // Wide enough for any practical operand width; only the low $clog2(W) bits are ever written.
  localparam int         FBIT_W  = 16;

  typedef enum logic [3:0] {
    NET_NONE = 4'd0,
    NET_A    = 4'd1,
    NET_B    = 4'd2,
    NET_CIN  = 4'd3,
    NET_AXB  = 4'd4,
    NET_SUM  = 4'd5,
    NET_AXBC = 4'd6,
    NET_AB   = 4'd7,
    NET_COUT = 4'd8
  } fault_net_e;

  typedef struct packed {
    logic [FBIT_W-1:0] bidx;
    logic [3:0]        code;
    logic              pol;
  } fault_cfg_t;

endpackage

// File: rtl/tmr_rc_adder_fa_fault_cell.sv
// One-bit full adder with a single injectable stuck-at fault on any internal net.
// Latency: combinational.
// Backpressure: none.
module fa_fault_cell
  import tmr_rc_adder_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [3:0] code,
  input  logic       en,
  input  logic       pol,
  output logic       s,
  output logic       co
);

  logic a_f, b_f, c_f, x_f, p_f, g_f;

  function automatic logic fnet(input fault_net_e net, input logic v);
    return (en && (code == net)) ? pol : v;
  endfunction

  // Faults on inputs propagate into every downstream net of this slice.
  always_comb begin
    a_f = fnet(NET_A, a);
    b_f = fnet(NET_B, b);
    c_f = fnet(NET_CIN, c);
    x_f = fnet(NET_AXB, a_f ^ b_f);
    s   = fnet(NET_SUM, x_f ^ c_f);
    p_f = fnet(NET_AXBC, x_f & c_f);
    g_f = fnet(NET_AB, a_f & b_f);
    co  = fnet(NET_COUT, g_f | p_f);
  end

endmodule

// File: rtl/tmr_rc_adder.sv
// TMR ripple-carry adder with fault injection, bitwise majority voter and disagreement stats; TMR_STUCK1_EN enables stuck-at-1.
// Latency: 1 cycle, throughput 1/cycle.
// Backpressure: in_ready = !out_valid | out_ready; a stalled result holds all outputs.
module tmr_rc_adder
  import tmr_rc_adder_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         sum,
  output logic                 cout,
  output logic [2:0]           rep_err,
  output logic                 uncorr,
  input  logic                 fault_we,
  input  logic [1:0]           fault_rep,
  input  logic [$clog2(W)-1:0] fault_bit,
  input  logic [4:0]           fault_code,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [2:0]           sticky,
  input  logic                 stat_clr
);

  localparam int BW = $clog2(W);

  fault_cfg_t cfg_q [NUM_REP];
  logic [W:0] rw [NUM_REP];
  logic [W:0] voted;
  logic [2:0] rep_err_n;
  logic       uncorr_n;
  logic       acc;
  logic       fault_bit_ok;
  logic       unused_pol;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // When W is a power of two every encodable slice index is legal.
  if ((1 << BW) == W) begin : g_bit_full
    assign fault_bit_ok = 1'b1;
  end else begin : g_bit_part
    assign fault_bit_ok = (fault_bit < BW'(W));
  end

`ifdef TMR_STUCK1_EN
  assign unused_pol = 1'b0;
`else
  assign unused_pol = fault_code[4];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REP; r++) cfg_q[r] <= '0;
    end else if (fault_we && fault_bit_ok) begin
      for (int r = 0; r < NUM_REP; r++) begin
        if (fault_rep == BCAST || fault_rep == 2'(r)) begin
          cfg_q[r].bidx <= FBIT_W'(fault_bit);
          cfg_q[r].code <= fault_code[3:0];
`ifdef TMR_STUCK1_EN
          cfg_q[r].pol  <= fault_code[4];
`else
          cfg_q[r].pol  <= 1'b0;
`endif
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_REP; r++) begin : g_rep
    logic [W-1:0] s_w;
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic ci, co;
      if (i == 0) begin : g_c0
        assign ci = cin;
      end else begin : g_cn
        assign ci = g_bit[i-1].co;
      end
      fa_fault_cell u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .c    (ci),
        .code (cfg_q[r].code),
        .en   (cfg_q[r].bidx == FBIT_W'(i)),
        .pol  (cfg_q[r].pol),
        .s    (s_w[i]),
        .co   (co)
      );
    end
    assign rw[r] = {g_bit[W-1].co, s_w};
  end

  always_comb begin
    voted = (rw[0] & rw[1]) | (rw[0] & rw[2]) | (rw[1] & rw[2]);
    rep_err_n = '0;
    for (int k = 0; k < NUM_REP; k++) rep_err_n[k] = (rw[k] != voted);
    uncorr_n = (rw[0] != rw[1]) && (rw[0] != rw[2]) && (rw[1] != rw[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      rep_err   <= '0;
      uncorr    <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      sum       <= voted[W-1:0];
      cout      <= voted[W];
      rep_err   <= rep_err_n;
      uncorr    <= uncorr_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle error event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sticky  <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
      sticky  <= '0;
    end else if (acc) begin
      if (|rep_err_n && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
      sticky <= sticky | rep_err_n;
    end
  end

endmodule

// File: tb/tb_tmr_rc_adder.sv
// Scoreboard bench for tmr_rc_adder (W=8, small counter to reach saturation quickly).
module tb_tmr_rc_adder;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [W-1:0]     a, b;
  logic             cin;
  logic             out_valid, out_ready;
  logic [W-1:0]     sum;
  logic             cout;
  logic [2:0]       rep_err;
  logic             uncorr;
  logic             fault_we;
  logic [1:0]       fault_rep;
  logic [2:0]       fault_bit;
  logic [4:0]       fault_code;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       sticky;
  logic             stat_clr;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic [2:0] re;
    logic       u;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   waited;

  tmr_rc_adder #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .rep_err(rep_err), .uncorr(uncorr),
    .fault_we(fault_we), .fault_rep(fault_rep), .fault_bit(fault_bit),
    .fault_code(fault_code), .err_cnt(err_cnt), .sticky(sticky), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a result is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got sum=%h cout=%b rep_err=%b uncorr=%b", sum, cout, rep_err, uncorr);
      end else begin
        me = exp_q.pop_front();
        if (sum !== me.s || cout !== me.c || rep_err !== me.re || uncorr !== me.u) begin
          errors++;
          $display("FAIL result got sum=%h cout=%b rep_err=%b uncorr=%b want sum=%h cout=%b rep_err=%b uncorr=%b",
                   sum, cout, rep_err, uncorr, me.s, me.c, me.re, me.u);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cfgw(input logic [1:0] rep, input logic [2:0] bt, input logic [4:0] code);
    fault_we = 1'b1; fault_rep = rep; fault_bit = bt; fault_code = code;
    @(posedge clk); #1;
    fault_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input logic [2:0] er, input logic eu,
                      output int nw);
    int n;
    int c0;
    exp_t e;
    e.s = es; e.c = ec; e.re = er; e.u = eu;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    exp_q.push_back(e);
    c0 = cyc; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck at 0");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    nw = cyc - c0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    fault_we = 1'b0; fault_rep = '0; fault_bit = '0; fault_code = '0; stat_clr = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", {cout, sum}, 0);
    chk("rst_rep_err", {uncorr, rep_err}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // No faults.
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b000, 1'b0, waited);
    chk("nofault_err_cnt", err_cnt, 0);

    // A config write alongside an accept only affects later accepts.
    fault_we = 1'b1; fault_rep = 2'd0; fault_bit = 3'd0; fault_code = 5'd5;
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b000, 1'b0, waited);
    fault_we = 1'b0;
    chk("samecyc_err_cnt", err_cnt, 0);
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b001, 1'b0, waited);
    chk("r0_err_cnt", err_cnt, 1);
    chk("r0_sticky", sticky, 3'b001);

    cfgw(2'd1, 3'd5, 5'd5);
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b011, 1'b1, waited);
    chk("uncorr_err_cnt", err_cnt, 2);
    chk("uncorr_sticky", sticky, 3'b011);

    // Codes above 8 inject nothing.
    cfgw(2'd3, 3'd0, 5'd9);
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b000, 1'b0, waited);
    chk("code9_err_cnt", err_cnt, 2);

    cfgw(2'd2, 3'd2, 5'd1);
    send(8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 3'b100, 1'b0, waited);
    chk("neta_err_cnt", err_cnt, 3);
    chk("neta_sticky", sticky, 3'b111);

    cfgw(2'd1, 3'd0, 5'd3);
    send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 3'b010, 1'b0, waited);
    chk("netcin_err_cnt", err_cnt, 4);

    // Common-mode fault: every replica agrees, voter cannot mask it.
    cfgw(2'd3, 3'd7, 5'd8);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, waited);
    chk("bcast_err_cnt", err_cnt, 4);
    @(posedge clk); #1;

    // Backpressure.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 3'b000, 1'b0, waited);
    me.s = 8'h30; me.c = 1'b0; me.re = 3'b000; me.u = 1'b0;
    exp_q.push_back(me);
    a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_sum", sum, 8'h03);
      chk("stall_err_cnt", err_cnt, 4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(8'h07, 8'h08, 1'b0, 8'h0F, 1'b0, 3'b000, 1'b0, waited);
    chk("tput_1", waited, 1);
    send(8'h40, 8'h3F, 1'b0, 8'h7F, 1'b0, 3'b000, 1'b0, waited);
    chk("tput_2", waited, 1);
    @(posedge clk); #1;

    // Reset with a result pending.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 3'b000, 1'b0, waited);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_sum", {cout, sum}, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    chk("mrst_sticky", sticky, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b000, 1'b0, waited);
    chk("cfgclr_err_cnt", err_cnt, 0);

    // Clear coinciding with an error event.
    cfgw(2'd0, 3'd0, 5'd5);
    stat_clr = 1'b1;
    send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b001, 1'b0, waited);
    stat_clr = 1'b0;
    chk("clrpri_err_cnt", err_cnt, 0);
    chk("clrpri_sticky", sticky, 0);

    for (int i = 0; i < 17; i++)
      send(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 3'b001, 1'b0, waited);
    chk("sat_err_cnt", err_cnt, 15);
    chk("sat_sticky", sticky, 3'b001);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);

    cfgw(2'd0, 3'd0, 5'd0);
    cfgw(2'd2, 3'd1, 5'h15);
`ifdef TMR_STUCK1_EN
    send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'b100, 1'b0, waited);
`else
    send(8'h02, 8'h00, 1'b0, 8'h02, 1'b0, 3'b100, 1'b0, waited);
`endif
    chk("pol_err_cnt", err_cnt, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
